// File: rtl/fir_coef_ctrl.sv
// Double-banked FIR coefficient store with a host write port and a sample-aligned bank swap.
// Optional shadow readback port enabled by defining FIR_COEF_READBACK_EN.
module fir_coef_ctrl #(
    parameter int NTAPS = 32,
    parameter int CW    = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [$clog2(NTAPS):0]   cfg_addr,
    input  logic [CW-1:0]            cfg_data,
    input  logic                     cfg_commit,
    input  logic                     sample_stb,
    input  logic [$clog2(NTAPS)-1:0] coef_rd_addr,
    output logic [CW-1:0]            coef_rd_data,
`ifdef FIR_COEF_READBACK_EN
    input  logic [$clog2(NTAPS)-1:0] rb_addr,
    output logic [CW-1:0]            rb_data,
`endif
    output logic                     busy,
    output logic                     swap_done,
    output logic                     addr_err
);

    localparam int AW = $clog2(NTAPS);
    localparam logic [AW:0] TAP_LIMIT = (AW+1)'(NTAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        SWAP  = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            ready_q;
    logic            bank_sel;
    logic            err_q;
    logic [CW-1:0]   rd_q;
    logic [CW-1:0]   bank [2][NTAPS];

    logic            wr_fire;
    logic            wr_in_range;
    logic            commit_ok;
    logic [AW-1:0]   wr_idx;

    // ready_q is low for the first cycle after reset, so writes and commits are gated by it
    assign wr_fire     = cfg_valid && ready_q;
    assign wr_in_range = cfg_addr < TAP_LIMIT;
    assign commit_ok   = cfg_commit && ready_q;
    assign wr_idx      = cfg_addr[AW-1:0];

    // State register; cfg_ready is registered so it reads 0 throughout reset
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!sys_rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == IDLE) || (next_state == LOAD);
        end
    end

    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (commit_ok)
                    next_state = ARMED;
                else if (wr_fire && wr_in_range)
                    next_state = LOAD;
            end
            LOAD: begin
                if (commit_ok)
                    next_state = ARMED;
            end
            ARMED: begin
                if (sample_stb)
                    next_state = SWAP;
            end
            SWAP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ARMED) || (state == SWAP);
        swap_done = (state == SWAP);
    end

    // bank_sel flips on entry to SWAP: reads sampled in SWAP already see the new bank
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bank_sel <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if ((state == ARMED) && sample_stb)
                bank_sel <= ~bank_sel;
            if (wr_fire && !wr_in_range)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: both banks must come out of reset as zero, so this array is cleared explicitly;
        // storage without that requirement would skip the reset branch.
        if (!sys_rst_n) begin
            for (int t = 0; t < NTAPS; t++) begin
                bank[0][t] <= '0;
                bank[1][t] <= '0;
            end
        end else if (wr_fire && wr_in_range) begin
            bank[~bank_sel][wr_idx] <= cfg_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            rd_q <= '0;
        else
            rd_q <= bank[bank_sel][coef_rd_addr];
    end

`ifdef FIR_COEF_READBACK_EN
    logic [CW-1:0] rb_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)
            rb_q <= '0;
        else
            rb_q <= bank[~bank_sel][rb_addr];
    end

    assign rb_data = rb_q;
`else
    // Shadow readback is absent in this build.
`endif

    assign cfg_ready    = ready_q;
    assign coef_rd_data = rd_q;
    assign addr_err     = err_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Scoreboard bench for fir_coef_ctrl: a driver steps a behavioural model and queues expectations,
// an independent monitor pops and compares one expectation per clock.
module tb_fir_coef_ctrl;

    localparam int NTAPS = 32;
    localparam int CW    = 16;
    localparam int AW    = 5;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW:0]   cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          cfg_commit;
    logic          sample_stb;
    logic [AW-1:0] coef_rd_addr;
    logic [CW-1:0] coef_rd_data;
    logic          busy;
    logic          swap_done;
    logic          addr_err;
`ifdef FIR_COEF_READBACK_EN
    logic [AW-1:0] rb_addr;
    logic [CW-1:0] rb_data;
    int            rb_force = -1;
`endif

    always #5 sys_clk = ~sys_clk;

    fir_coef_ctrl #(.NTAPS(NTAPS), .CW(CW)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_commit   (cfg_commit),
        .sample_stb   (sample_stb),
        .coef_rd_addr (coef_rd_addr),
        .coef_rd_data (coef_rd_data),
`ifdef FIR_COEF_READBACK_EN
        .rb_addr      (rb_addr),
        .rb_data      (rb_data),
`endif
        .busy         (busy),
        .swap_done    (swap_done),
        .addr_err     (addr_err)
    );

    typedef struct {
        logic [CW-1:0] rd;
        logic          ready;
        logic          busy;
        logic          swp;
        logic          err;
`ifdef FIR_COEF_READBACK_EN
        logic [CW-1:0] rb;
`endif
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: two coefficient arrays, which one the filter sees, and whether a commit is pending
    logic [CW-1:0] m_bank [2][NTAPS];
    bit            m_act;
    bit            m_ready;
    bit            m_armed;
    bit            m_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   go_swap;
        bit   go_armed;
        e = '{default: '0};
        if (!sys_rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int t = 0; t < NTAPS; t++)
                    m_bank[b][t] = '0;
            m_act   = 1'b0;
            m_ready = 1'b0;
            m_armed = 1'b0;
            m_err   = 1'b0;
        end else begin
            e.rd = m_bank[m_act][coef_rd_addr];
`ifdef FIR_COEF_READBACK_EN
            e.rb = m_bank[!m_act][rb_addr];
`endif
            if (cfg_valid && m_ready) begin
                if (int'(cfg_addr) < NTAPS)
                    m_bank[!m_act][cfg_addr[AW-1:0]] = cfg_data;
                else
                    m_err = 1'b1;
            end
            // A strobe only swaps once the commit has already been taken on an earlier cycle
            go_swap  = m_armed && sample_stb;
            go_armed = (m_armed && !sample_stb) || (m_ready && cfg_commit);
            if (go_swap)
                m_act = !m_act;
            m_armed = go_armed;
            m_ready = !go_armed && !go_swap;
            e.ready = m_ready;
            e.busy  = go_armed || go_swap;
            e.swp   = go_swap;
            e.err   = m_err;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit rst_n_v, input bit v, input int a, input int d,
                       input bit c, input bit s, input int r);
        @(negedge sys_clk);
        sys_rst_n    = rst_n_v;
        cfg_valid    = v;
        cfg_addr     = (AW+1)'(a);
        cfg_data     = CW'(d);
        cfg_commit   = c;
        sample_stb   = s;
        coef_rd_addr = AW'(r);
`ifdef FIR_COEF_READBACK_EN
        rb_addr = (rb_force >= 0) ? AW'(rb_force) : AW'($urandom_range(0, NTAPS-1));
`endif
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1, 0, 0, 0, 0, 0, $urandom_range(0, NTAPS-1));
    endtask

    task automatic read_all();
        for (int i = 0; i < NTAPS; i++)
            cyc(1, 0, 0, 0, 0, 0, i);
    endtask

    // Monitor: one expectation per clock, compared just after the edge that produced it
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("coef_rd_data", 32'(coef_rd_data), 32'(e.rd));
                check("cfg_ready",    32'(cfg_ready),    32'(e.ready));
                check("busy",         32'(busy),         32'(e.busy));
                check("swap_done",    32'(swap_done),    32'(e.swp));
                check("addr_err",     32'(addr_err),     32'(e.err));
`ifdef FIR_COEF_READBACK_EN
                check("rb_data",      32'(rb_data),      32'(e.rb));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        cfg_commit = 1'b0; sample_stb = 1'b0; coef_rd_addr = '0;
`ifdef FIR_COEF_READBACK_EN
        rb_addr = '0;
`endif
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);

        // Post-reset: all taps read zero, controller ready
        read_all();
        idle(1);

        // Ramp load, commit, strobe five cycles after the commit
        for (int k = 0; k < NTAPS; k++)
            cyc(1, 1, k, k*100 - 1600, 0, 0, $urandom_range(0, NTAPS-1));
        cyc(1, 0, 0, 0, 1, 0, 0);
        idle(4);
        cyc(1, 0, 0, 0, 0, 1, 0);
        idle(3);
        read_all();

        // Out-of-range write is dropped and flagged
        cyc(1, 1, 40, 16'h7fff, 0, 0, 0);
        idle(3);
        read_all();

        // Strobe on the commit cycle does not count; writes stall while armed
        cyc(1, 1, 7, 1234, 0, 0, 7);
        cyc(1, 0, 0, 0, 1, 1, 7);
        for (int i = 0; i < 4; i++) cyc(1, 1, 5, 16'h1234, 0, 0, 5);
        cyc(1, 1, 5, 16'h1234, 0, 1, 7);
        cyc(1, 1, 5, 16'h1234, 0, 0, 7);
        cyc(1, 1, 5, 16'h1234, 0, 0, 5);
        idle(3);
        read_all();

        // Shadow write to tap 3 then swap; readback tracks the shadow bank
`ifdef FIR_COEF_READBACK_EN
        rb_force = 3;
`endif
        cyc(1, 1, 3, -7, 0, 0, 3);
        idle(2);
        cyc(1, 0, 0, 0, 1, 0, 3);
        idle(2);
        cyc(1, 0, 0, 0, 0, 1, 3);
        idle(4);
`ifdef FIR_COEF_READBACK_EN
        rb_force = -1;
`endif

        // Reset while armed: everything back to zero, no swap
        cyc(1, 1, 9, 999, 0, 0, 9);
        cyc(1, 0, 0, 0, 1, 0, 9);
        idle(3);
        cyc(0, 0, 0, 0, 0, 1, 9);
        cyc(0, 0, 0, 0, 0, 1, 9);
        idle(2);
        read_all();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            int a;
            a = ($urandom_range(0, 15) == 0) ? $urandom_range(NTAPS, 2*NTAPS-1)
                                             : $urandom_range(0, NTAPS-1);
            cyc(1, $urandom_range(0, 1) == 1, a, $urandom,
                $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, NTAPS-1));
        end
        idle(2);

        @(posedge sys_clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_coef_ctrl.md
FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 32, number of FIR taps / coefficient words per bank.
REQ-002 SHALL have parameter CW, default 16, coefficient width (signed two's complement).
REQ-003 SHALL have port sys_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cfg_valid  input  1  host write request.
REQ-006 SHALL have port cfg_ready  output  1  controller accepts a write this cycle.
REQ-007 SHALL have port cfg_addr  input  $clog2(NTAPS)+1  tap index; MSB allows out-of-range detection.
REQ-008 SHALL have port cfg_data  input  CW  signed coefficient to write.
REQ-009 SHALL have port cfg_commit  input  1  one-cycle pulse requesting a bank swap.
REQ-010 SHALL have port sample_stb  input  1  one-cycle FIR sample-boundary strobe, at most one per 100 MHz sample.
REQ-011 SHALL have port coef_rd_addr  input  $clog2(NTAPS)  FIR tap read index.
REQ-012 SHALL have port coef_rd_data  output  CW  active-bank coefficient at coef_rd_addr.
REQ-013 SHALL have port busy  output  1  high in ARMED and SWAP.
REQ-014 SHALL have port swap_done  output  1  one-cycle pulse after a swap.
REQ-015 SHALL have port addr_err  output  1  sticky out-of-range write flag.

Function
REQ-016 SHALL hold two banks of NTAPS x CW registers; bank_sel selects the active bank, the other is shadow.
REQ-017 SHALL implement FSM states IDLE, LOAD, ARMED, SWAP.
REQ-018 SHALL assert cfg_ready in IDLE and LOAD, deassert in ARMED and SWAP.
REQ-019 SHALL on cfg_valid&&cfg_ready with cfg_addr<NTAPS write cfg_data to shadow[cfg_addr]; IDLE->LOAD.
REQ-020 SHALL on cfg_valid&&cfg_ready with cfg_addr>=NTAPS drop the write and set addr_err until reset.
REQ-021 SHALL on cfg_commit in IDLE or LOAD go to ARMED next cycle; cfg_commit in ARMED/SWAP ignored.
REQ-022 SHALL, when cfg_valid and cfg_commit coincide in IDLE/LOAD, perform the write and then arm.
REQ-023 SHALL in ARMED wait for sample_stb, then enter SWAP; sample_stb coincident with the commit cycle does not count.
REQ-024 SHALL in SWAP toggle bank_sel, pulse swap_done for that single cycle, go to IDLE next cycle.
REQ-025 SHALL register coef_rd_data: value = active[coef_rd_addr] sampled one cycle earlier (latency 1).
REQ-026 SHALL switch coef_rd_data to the new bank on the cycle after SWAP; no mixed-bank read in any cycle.
REQ-027 SHALL leave the shadow bank contents unchanged by a swap (old active becomes editable shadow).

Reset
REQ-028 SHALL, on sys_rst_n low at a clock edge, clear both banks to 0, bank_sel=0, state IDLE.
REQ-029 SHALL reset outputs: cfg_ready=0 during reset, 1 first cycle after; coef_rd_data=0, busy=0, swap_done=0, addr_err=0.
REQ-030 SHALL discard any pending commit and in-progress load when reset asserts mid-operation.

Configuration
REQ-031 SHALL, with macro FIR_COEF_READBACK_EN defined, add input rb_addr ($clog2(NTAPS)) and output rb_data (CW) = shadow[rb_addr] registered, latency 1, reset 0.
REQ-032 SHALL, without FIR_COEF_READBACK_EN, omit rb_addr/rb_data and all readback logic; other behaviour identical.

Verification
REQ-033 SHALL test: after reset, coef_rd_addr=0..31 -> coef_rd_data=0 every read, busy=0, cfg_ready=1.
REQ-034 SHALL test: write shadow[k]=k*100-1600 for k=0..31, commit, sample_stb 5 cycles later -> swap_done 1 pulse, reads return k*100-1600.
REQ-035 SHALL test: write cfg_addr=40 -> addr_err=1 and stays, no bank changed.
REQ-036 SHALL test: commit with sample_stb same cycle -> no swap; next sample_stb -> swap; cfg_valid during ARMED stalled by cfg_ready=0.
REQ-037 SHALL test: reset asserted in ARMED -> IDLE, bank_sel=0, all reads 0, no swap_done.
REQ-038 SHALL test (FIR_COEF_READBACK_EN): write shadow[3]=-7, rb_addr=3 -> rb_data=-7 next cycle; after swap rb_data shows old active[3].
